// File: rtl/router_pkg.sv
// router_pkg: port indices, header field positions and flit type shared by the router files
package router_pkg;
    localparam int NUM_PORTS = 6;
    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_S = 2;
    localparam int P_W = 3;
    localparam int P_L = 4;
    localparam int P_EXT = 5;
    localparam int MCAST_BIT = 31;
    localparam int MASK_LSB = 26;
    localparam int MASK_W = 5;
    localparam int DEST_LSB = 26;
    localparam int DEST_W = 3;
    localparam int FLIT_W_DEFAULT = 64;
    typedef logic [FLIT_W_DEFAULT-1:0] flit_t;
endpackage

// File: rtl/router_fifo.sv
// router_fifo: per-source flit buffer whose head is read straight from storage
module router_fifo
    import router_pkg::*;
#(
    parameter int W = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_cnt;
    logic w_push, w_pop;
    assign w_pop = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);
    assign o_full = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_dout = r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd <= '0;
            r_wr <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end
endmodule

// File: rtl/router_cell.sv
// router_cell: 5+1 port mesh router with per-source FIFOs, round-robin all-or-nothing allocation and registered outputs
module router_cell
    import router_pkg::*;
#(
    parameter int FLIT_W = 64,
    parameter int ENABLE_MCAST = 0,
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FLIT_W*5-1:0] flit_in_flat,
    input  logic [4:0]          valid_in_flat,
    output logic [4:0]          ready_out_flat,
    output logic [FLIT_W*5-1:0] flit_out_flat,
    output logic [4:0]          valid_out_flat,
    input  logic [4:0]          ready_in_flat,
    input  logic [FLIT_W-1:0]   ext_flit_in,
    input  logic                ext_valid_in,
    output logic                ext_ready_out,
    output logic [FLIT_W-1:0]   ext_flit_out,
    output logic                ext_valid_out,
    input  logic                ext_ready_in
);
    localparam logic [FLIT_W-1:0] MCAST_MASK = FLIT_W'(1) << MCAST_BIT;
    logic [FLIT_W-1:0] w_in_flit [NUM_PORTS];
    logic [FLIT_W-1:0] w_head [NUM_PORTS];
    logic [FLIT_W-1:0] w_copy [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_dest [NUM_PORTS];
    logic [2:0] w_osel [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_in_valid, w_out_ready, w_push, w_full, w_empty, w_ready;
    logic [NUM_PORTS-1:0] w_grant, w_claim, w_free, w_mcast;
    logic [3:0] w_sum;
    logic [2:0] w_idx, w_last, w_rr_nxt;
    logic w_any;
    logic [FLIT_W-1:0] r_oflit [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_ovalid;
    logic [2:0] r_rr;
    logic r_live;
    assign w_in_valid = {ext_valid_in, valid_in_flat};
    assign w_out_ready = {ext_ready_in, ready_in_flat};
    assign w_ready = {NUM_PORTS{r_live}} & ~w_full;
    assign w_push = w_in_valid & w_ready;
    assign w_free = ~r_ovalid | w_out_ready;
    assign ready_out_flat = w_ready[P_L:0];
    assign ext_ready_out = w_ready[P_EXT];
    assign valid_out_flat = r_ovalid[P_L:0];
    assign ext_valid_out = r_ovalid[P_EXT];
    assign ext_flit_out = r_oflit[P_EXT];
    assign w_in_flit[P_EXT] = ext_flit_in;
    for (genvar s = 0; s < NUM_PORTS; s++) begin : g_src
        if (s < P_EXT) begin : g_flat
            assign w_in_flit[s] = flit_in_flat[s*FLIT_W +: FLIT_W];
            assign flit_out_flat[s*FLIT_W +: FLIT_W] = r_oflit[s];
        end
        router_fifo #(.W(FLIT_W), .DEPTH(BUF_DEPTH)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .i_push (w_push[s]),
            .i_din  (w_in_flit[s]),
            .i_pop  (w_grant[s]),
            .o_dout (w_head[s]),
            .o_full (w_full[s]),
            .o_empty(w_empty[s])
        );
        assign w_mcast[s] = (ENABLE_MCAST != 0) && w_head[s][MCAST_BIT];
        assign w_copy[s] = w_mcast[s] ? w_head[s] & ~MCAST_MASK : w_head[s];
        // unicast codes above the local port all eject to the host
        assign w_dest[s] = w_mcast[s] ? {1'b0, w_head[s][MASK_LSB +: MASK_W]}
                         : w_head[s][DEST_LSB +: DEST_W] > DEST_W'(P_L) ? NUM_PORTS'(1) << P_EXT
                         : NUM_PORTS'(1) << w_head[s][DEST_LSB +: DEST_W];
    end
    always_comb begin
        w_claim = '0;
        w_grant = '0;
        w_any = 1'b0;
        w_last = r_rr;
        w_sum = '0;
        w_idx = r_rr;
        for (int o = 0; o < NUM_PORTS; o++) w_osel[o] = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = {1'b0, r_rr} + 4'(k);
            w_idx = w_sum >= 4'(NUM_PORTS) ? 3'(w_sum - 4'(NUM_PORTS)) : w_sum[2:0];
            if (!w_empty[w_idx] && (w_dest[w_idx] & (w_claim | ~w_free)) == '0) begin
                w_grant[w_idx] = 1'b1;
                for (int o = 0; o < NUM_PORTS; o++) if (w_dest[w_idx][o]) w_osel[o] = w_idx;
                w_claim = w_claim | w_dest[w_idx];
                w_last = w_idx;
                w_any = 1'b1;
            end
        end
        w_rr_nxt = (w_last == 3'(P_EXT)) ? '0 : w_last + 3'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovalid <= '0;
            r_rr <= '0;
            r_live <= 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) r_oflit[o] <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_any) r_rr <= w_rr_nxt;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_claim[o]) begin
                    r_ovalid[o] <= 1'b1;
                    r_oflit[o] <= w_copy[w_osel[o]];
                end else if (w_out_ready[o]) begin
                    r_ovalid[o] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_cell.sv
// tb_router_cell: directed vector table plus multi-cycle sequences for router_cell
module tb_router_cell;
    import router_pkg::*;
    typedef struct {
        int          src;
        logic [31:0] lo;
        logic [5:0]  exp_v;
        logic [31:0] exp_lo;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    logic [319:0] flit_in_flat;
    logic [4:0] valid_in_flat, ready_in_flat;
    logic [63:0] ext_flit_in;
    logic ext_valid_in, ext_ready_in;
    logic [4:0] ready_out_flat, valid_out_flat;
    logic [319:0] flit_out_flat;
    logic ext_ready_out, ext_valid_out;
    logic [63:0] ext_flit_out;
    logic [4:0] d0_ready_out, d0_valid_out;
    logic [319:0] d0_flit_out;
    logic d0_ext_ready, d0_ext_valid;
    logic [63:0] d0_ext_flit;
    logic [5:0] ov;
    int checks = 0;
    int errors = 0;
    vec_t vecs[10];
    logic [31:0] rx[$];
    flit_t f;
    assign ov = {ext_valid_out, valid_out_flat};
    always #5 clk = ~clk;
    router_cell #(.FLIT_W(64), .ENABLE_MCAST(1), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .flit_in_flat(flit_in_flat), .valid_in_flat(valid_in_flat), .ready_out_flat(ready_out_flat),
        .flit_out_flat(flit_out_flat), .valid_out_flat(valid_out_flat), .ready_in_flat(ready_in_flat),
        .ext_flit_in(ext_flit_in), .ext_valid_in(ext_valid_in), .ext_ready_out(ext_ready_out),
        .ext_flit_out(ext_flit_out), .ext_valid_out(ext_valid_out), .ext_ready_in(ext_ready_in)
    );
    router_cell #(.FLIT_W(64), .ENABLE_MCAST(0), .BUF_DEPTH(2)) dut0 (
        .clk(clk), .rst(rst),
        .flit_in_flat(flit_in_flat), .valid_in_flat(valid_in_flat), .ready_out_flat(d0_ready_out),
        .flit_out_flat(d0_flit_out), .valid_out_flat(d0_valid_out), .ready_in_flat(ready_in_flat),
        .ext_flit_in(ext_flit_in), .ext_valid_in(ext_valid_in), .ext_ready_out(d0_ext_ready),
        .ext_flit_out(d0_ext_flit), .ext_valid_out(d0_ext_valid), .ext_ready_in(ext_ready_in)
    );
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input int src, input logic [63:0] fl, input logic v);
        if (src == 5) begin
            ext_flit_in = fl;
            ext_valid_in = v;
        end else begin
            flit_in_flat[src*64 +: 64] = fl;
            valid_in_flat[src] = v;
        end
    endtask
    function automatic logic [63:0] out_flit(input int o);
        return o == 5 ? ext_flit_out : flit_out_flat[o*64 +: 64];
    endfunction
    task automatic do_reset;
        rst = 1'b1;
        valid_in_flat = '0;
        ext_valid_in = 1'b0;
        ready_in_flat = 5'h1f;
        ext_ready_in = 1'b1;
        step;
        step;
        rst = 1'b0;
        step;
    endtask
    initial begin
        int acc, acc_now, an, as_, n_cnt, s_cnt, bad, bad2, ni, si, idle;
        vecs[0] = '{0, 32'h0800_00AA, 6'b000100, 32'h0800_00AA};
        vecs[1] = '{0, 32'h1400_00AA, 6'b100000, 32'h1400_00AA};
        vecs[2] = '{5, 32'hA800_0003, 6'b001010, 32'h2800_0003};
        vecs[3] = '{2, 32'h0800_0011, 6'b000100, 32'h0800_0011};
        vecs[4] = '{4, 32'h1C00_0005, 6'b100000, 32'h1C00_0005};
        vecs[5] = '{1, 32'hFC00_0007, 6'b011111, 32'h7C00_0007};
        vecs[6] = '{3, 32'h8000_0009, 6'b000000, 32'h0};
        vecs[7] = '{4, 32'h1000_0001, 6'b010000, 32'h1000_0001};
        vecs[8] = '{3, 32'h0000_0042, 6'b000001, 32'h0000_0042};
        vecs[9] = '{1, 32'h6800_0003, 6'b000100, 32'h6800_0003};
        rst = 1'b1;
        flit_in_flat = '0;
        valid_in_flat = '0;
        ready_in_flat = 5'h1f;
        ext_flit_in = '0;
        ext_valid_in = 1'b0;
        ext_ready_in = 1'b1;
        step;
        step;
        check("rst ready", 64'(ready_out_flat), 64'h0);
        check("rst ext_ready", 64'(ext_ready_out), 64'h0);
        check("rst valids", 64'(ov), 64'h0);
        check("rst flits", 64'(|flit_out_flat), 64'h0);
        check("rst ext flit", ext_flit_out, 64'h0);
        rst = 1'b0;
        step;
        check("post rst ready", 64'(ready_out_flat), 64'h1f);
        check("post rst ext_ready", 64'(ext_ready_out), 64'h1);
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].src, {32'hA5A5_0000 | 32'(i), vecs[i].lo}, 1'b1);
            step;
            drive(vecs[i].src, 64'h0, 1'b0);
            step;
            check($sformatf("vec%0d valid", i), 64'(ov), 64'(vecs[i].exp_v));
            for (int o = 0; o < 6; o++)
                if (vecs[i].exp_v[o])
                    check($sformatf("vec%0d out%0d", i, o), out_flit(o), {32'hA5A5_0000 | 32'(i), vecs[i].exp_lo});
            step;
            check($sformatf("vec%0d idle", i), 64'(ov), 64'h0);
        end
        do_reset;
        ready_in_flat = 5'b10111;
        drive(0, 64'h0C00_0001, 1'b1);
        step;
        drive(0, 64'h0, 1'b0);
        drive(5, 64'hA800_0003, 1'b1);
        step;
        drive(5, 64'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check("bp E blocked", 64'(valid_out_flat[1]), 64'h0);
            check("bp W held", out_flit(3), 64'h0C00_0001);
            step;
        end
        ready_in_flat = 5'h1f;
        step;
        check("bp both valid", 64'(ov), 64'b001010);
        check("bp E copy", out_flit(1), 64'h2800_0003);
        check("bp W copy", out_flit(3), 64'h2800_0003);
        step;
        check("bp once", 64'(ov), 64'h0);
        do_reset;
        ready_in_flat = 5'b11101;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            acc_now = ready_out_flat[0] ? 1 : 0;
            drive(0, acc_now == 1 ? 64'h0400_0000 | 64'(acc) : 64'h0400_00FF, 1'b1);
            step;
            acc += acc_now;
        end
        check("full accepts", 64'(acc), 64'd3);
        check("full ready low", 64'(ready_out_flat[0]), 64'h0);
        drive(0, 64'h0, 1'b0);
        ready_in_flat = 5'h1f;
        rx.delete();
        for (int c = 0; c < 8; c++) begin
            f = out_flit(1);
            if (valid_out_flat[1]) rx.push_back(f[31:0]);
            step;
        end
        check("full drained count", 64'(rx.size()), 64'd3);
        for (int i = 0; i < rx.size(); i++) check($sformatf("full order%0d", i), 64'(rx[i]), 64'h0400_0000 | 64'(i));
        check("full ready back", 64'(ready_out_flat[0]), 64'h1);
        do_reset;
        rx.delete();
        n_cnt = 0;
        s_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 64'h1000_0100 + 64'(n_cnt), 1'b1);
            drive(2, 64'h1000_0200 + 64'(s_cnt), 1'b1);
            an = ready_out_flat[0] ? 1 : 0;
            as_ = ready_out_flat[2] ? 1 : 0;
            f = out_flit(4);
            if (valid_out_flat[4]) rx.push_back(f[31:0]);
            step;
            n_cnt += an;
            s_cnt += as_;
        end
        drive(0, 64'h0, 1'b0);
        drive(2, 64'h0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            f = out_flit(4);
            if (valid_out_flat[4]) rx.push_back(f[31:0]);
            step;
        end
        check("rr total", 64'(rx.size()), 64'(n_cnt + s_cnt));
        check("rr first is N", 64'(rx[0][11:8]), 64'h1);
        bad = 0;
        bad2 = 0;
        ni = 0;
        si = 0;
        for (int i = 0; i < rx.size(); i++) begin
            if (i > 0 && rx[i][11:8] == rx[i-1][11:8]) bad++;
            if (rx[i][11:8] == 4'h1) begin
                if (rx[i][7:0] != 8'(ni)) bad2++;
                ni++;
            end else begin
                if (rx[i][7:0] != 8'(si)) bad2++;
                si++;
            end
        end
        check("rr alternation", 64'(bad), 64'h0);
        check("rr order", 64'(bad2), 64'h0);
        check("rr no starvation", 64'(ni >= 8 && si >= 8), 64'h1);
        do_reset;
        drive(0, 64'h8C00_0001, 1'b1);
        step;
        drive(0, 64'h0, 1'b0);
        step;
        check("nomc valid", 64'({d0_ext_valid, d0_valid_out}), 64'b001000);
        check("nomc flit", d0_flit_out[3*64 +: 64], 64'h8C00_0001);
        check("mc valid", 64'(ov), 64'b000011);
        check("mc flit", out_flit(0), 64'h0C00_0001);
        do_reset;
        ready_in_flat = '0;
        ext_ready_in = 1'b0;
        drive(0, 64'h0400_0001, 1'b1);
        drive(1, 64'h0800_0002, 1'b1);
        step;
        step;
        step;
        drive(0, 64'h0, 1'b0);
        drive(1, 64'h0, 1'b0);
        step;
        check("mid busy", 64'(ov), 64'b000110);
        rst = 1'b1;
        step;
        check("mid rst valids", 64'(ov), 64'h0);
        check("mid rst ready", 64'({ext_ready_out, ready_out_flat}), 64'h0);
        rst = 1'b0;
        ready_in_flat = 5'h1f;
        ext_ready_in = 1'b1;
        step;
        idle = 0;
        for (int c = 0; c < 4; c++) begin
            if (ov != 6'h0) idle++;
            step;
        end
        check("mid discarded", 64'(idle), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
